instr_sequencer: RTL and testbench
==================================

// Module: instr_sequencer
// PURPOSE
//  Multi-phase instruction sequencer for the 4-bit computer.
//  - Replaces the free-running program counter and single clock-phase strobe.
//  - Steps each instruction through FETCH/DECODE/EXEC/WRITE and emits one-cycle
//    load enables for the address and accumulator registers, plus the RAM write strobe.
//  - Adds run/single-step control, jump and halt.
//  - Sits between the program ROM / control ROM and the datapath registers.
// PARAMETERS
//  PC_W     4   program counter width (program ROM depth 2**PC_W)
//  INSTR_W  8   program ROM word width; [3:0] operand, [7:4] ALU select
//  CTRL_W   10  control ROM word width
//  WE_BIT   1   ctrl bit: store accumulator to RAM
//  JUMP_BIT 2   ctrl bit: PC <= operand
//  HALT_BIT 0   ctrl bit: halt
// PORTS
//  clk       in   1        system clock, rising edge
//  rst       in   1        synchronous reset, active-high
//  run_i     in   1        level; 1 = free-run instructions back to back
//  step_req  in   1        single-step request; rising edge is accepted in IDLE
//  step_ack  out  1        one-cycle pulse when the stepped instruction retires
//  instr_i   in   INSTR_W  program ROM word at pc_o (combinational ROM)
//  ctrl_i    in   CTRL_W   control ROM word for instr_i[3:0]
//  pc_o      out  PC_W     program counter, drives program ROM address
//  ir_o      out  INSTR_W  latched instruction, drives ALU select and mux operand
//  cr_o      out  CTRL_W   latched control word, drives mux select, M and Cn
//  addr_en   out  1        address register load enable
//  acc_en    out  1        accumulator load enable
//  ram_we    out  1        RAM write enable
//  phase_o   out  3        current state encoding (debug)
//  halted    out  1        1 while in HALT
//  ret_cnt   out  8        retired-instruction counter, wraps 255->0
// BEHAVIOUR
//  Reset, synchronous on rst=1:
//   - state=IDLE; pc_o, ir_o, cr_o, ret_cnt = 0; all enables, step_ack, halted = 0.
//   - Step-edge detector cleared.
//   - rst is honoured in any state, including mid-instruction and HALT.
//  All outputs are registered or decoded from the state register only (Moore);
//  nothing is combinational from the inputs.
//  States:
//   - IDLE: run_i=1 -> FETCH (run mode); else step_req rising edge -> FETCH (step mode).
//     run_i has priority when both are present.
//   - FETCH: ir_o<=instr_i, cr_o<=ctrl_i -> DECODE.
//   - DECODE:
//     - If cr_o[HALT_BIT]=1 -> HALT; no enables asserted, pc unchanged.
//     - Else addr_en=1 for this cycle -> EXEC.
//   - EXEC: ram_we=cr_o[WE_BIT]. RAM is written with the pre-update accumulator -> WRITE.
//   - WRITE:
//     - acc_en=1 unless cr_o[WE_BIT]=1.
//     - pc_o <= cr_o[JUMP_BIT] ? ir_o[3:0] : pc_o+1, mod 2**PC_W (15 -> 0).
//     - ret_cnt+1.
//     - Next: step mode -> step_ack=1 next cycle, -> IDLE; run_i=1 -> FETCH; else -> IDLE.
//   - HALT: halted=1, all enables 0; exited only by rst. run_i and step_req are ignored.
//  Timing:
//   - Latency is 4 clk per instruction.
//   - addr_en, ram_we and acc_en are each high for exactly one cycle, never together.
//  Run and step interaction:
//   - run_i falling mid-instruction: the instruction completes, then IDLE.
//   - step_req while not in IDLE is ignored and its edge is not queued.
//   - step_req held high yields exactly one instruction; it must fall and rise again
//     for the next step.
//   - run_i rising during a step-mode instruction: that instruction still pulses
//     step_ack, returns to IDLE, then enters run mode.
//  Jump to own address (operand = pc) loops forever in run mode; this is legal.
// STRUCTURE
//  - Package cpu_pkg: state_t enum (IDLE, FETCH, DECODE, EXEC, WRITE, HALT),
//    PC_W/INSTR_W/CTRL_W, WE_BIT/JUMP_BIT/HALT_BIT localparams.
//    The ControlROM and mux share these.
//  - One sub-module, seq_pc_reg: PC register with load/increment/wrap.
//  - The FSM and edge detector live in the top.
// TESTING
//  1. rst mid-EXEC with ram_we=1 -> next cycle state IDLE, pc_o=0, ram_we=0,
//     ret_cnt=0, halted=0.
//  2. run_i=1, ROM has no jump/halt -> pc_o 0,1,...,15,0 every 4 clk;
//     addr_en/ram_we/acc_en one-hot pulses; ret_cnt=16 after 64 clk.
//  3. Step mode: step_req held high 20 clk -> exactly one instruction;
//     step_ack one pulse at clk 5; pc_o=1; no second step until step_req toggles.
//  4. Instr at pc=3 with ctrl[JUMP_BIT]=1, operand 4'hA -> next fetch at pc_o=10;
//     acc_en asserted in WRITE.
//  5. Store instr (ctrl[WE_BIT]=1) -> ram_we=1 in EXEC only, acc_en=0 in WRITE.
//     Then a HALT instr -> halted=1 after DECODE, pc unchanged, run_i/step_req ignored
//     until rst.
//  6. run_i dropped during DECODE -> instruction finishes (acc_en pulse), then IDLE;
//     step_req during EXEC has no effect.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the 4-bit computer: word widths, control-word bit
// positions and the sequencer state encoding.
package cpu_pkg;

    localparam int PC_W     = 4;
    localparam int INSTR_W  = 8;
    localparam int CTRL_W   = 10;
    localparam int WE_BIT   = 1;
    localparam int JUMP_BIT = 2;
    localparam int HALT_BIT = 0;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        WRITE  = 3'd4,
        HALT   = 3'd5
    } state_t;

    // PC advance rule: a jump takes the operand, otherwise increment and wrap.
    function automatic logic [PC_W-1:0] nextPc(input logic [PC_W-1:0] pc,
                                               input logic            jump,
                                               input logic [PC_W-1:0] target);
        return jump ? target : pc + 1'b1;
    endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Bus between the sequencer, the program/control ROMs and the datapath registers.
// The master side is the sequencer itself.
interface instr_sequencer_if;
    import cpu_pkg::*;

    logic               run_i;
    logic               step_req;
    logic               step_ack;
    logic [INSTR_W-1:0] instr_i;
    logic [CTRL_W-1:0]  ctrl_i;
    logic [PC_W-1:0]    pc_o;
    logic [INSTR_W-1:0] ir_o;
    logic [CTRL_W-1:0]  cr_o;
    logic               addr_en;
    logic               acc_en;
    logic               ram_we;
    logic [2:0]         phase_o;
    logic               halted;
    logic [7:0]         ret_cnt;

    modport master (
        input  run_i, step_req, instr_i, ctrl_i,
        output step_ack, pc_o, ir_o, cr_o, addr_en, acc_en, ram_we,
               phase_o, halted, ret_cnt
    );

    modport slave (
        output run_i, step_req, instr_i, ctrl_i,
        input  step_ack, pc_o, ir_o, cr_o, addr_en, acc_en, ram_we,
               phase_o, halted, ret_cnt
    );

endinterface

// File: rtl/seq_pc_reg.sv
// Program counter: holds its value unless loaded, then jumps or increments
// with wrap-around at the top of program ROM.
module seq_pc_reg
    import cpu_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            jump,
    input  logic [PC_W-1:0] target,
    output logic [PC_W-1:0] pc
);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= '0;
        end else if (load) begin
            pc <= nextPc(pc, jump, target);
        end
    end

endmodule

// File: rtl/instr_sequencer.sv
// Four-phase instruction sequencer with run/single-step control, jump and halt.
// Every output comes from registers or from the state register alone.
module instr_sequencer
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    instr_sequencer_if.master  bus
);

    state_t             state;
    state_t             stateNext;
    logic               stepMode;
    logic               stepModeNext;
    logic               stepPrev;
    logic               stepEdge;
    logic               stepAck;
    logic [INSTR_W-1:0] ir;
    logic [CTRL_W-1:0]  cr;
    logic [7:0]         retCnt;
    logic [PC_W-1:0]    pc;
    logic               pcLoad;

    // The edge detector tracks step_req every cycle, so an edge seen outside
    // IDLE is consumed and never queued.
    assign stepEdge = bus.step_req & ~stepPrev;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            stepMode <= 1'b0;
            stepPrev <= 1'b0;
            stepAck  <= 1'b0;
            ir       <= '0;
            cr       <= '0;
            retCnt   <= '0;
        end else begin
            state    <= stateNext;
            stepMode <= stepModeNext;
            stepPrev <= bus.step_req;
            stepAck  <= (state == WRITE) && stepMode;
            if (state == FETCH) begin
                ir <= bus.instr_i;
                cr <= bus.ctrl_i;
            end
            if (state == WRITE) begin
                retCnt <= retCnt + 8'd1;
            end
        end
    end

    always_comb begin
        stateNext    = state;
        stepModeNext = stepMode;
        case (state)
            IDLE: begin
                if (bus.run_i) begin
                    stateNext    = FETCH;
                    stepModeNext = 1'b0;
                end else if (stepEdge) begin
                    stateNext    = FETCH;
                    stepModeNext = 1'b1;
                end
            end
            FETCH:  stateNext = DECODE;
            DECODE: stateNext = cr[HALT_BIT] ? HALT : EXEC;
            EXEC:   stateNext = WRITE;
            // A stepped instruction always returns to IDLE, even if run_i rose meanwhile.
            WRITE: begin
                if (stepMode) begin
                    stateNext = IDLE;
                end else if (bus.run_i) begin
                    stateNext = FETCH;
                end else begin
                    stateNext = IDLE;
                end
            end
            HALT:    stateNext = HALT;
            default: stateNext = IDLE;
        endcase
    end

    assign pcLoad = (state == WRITE);

    seq_pc_reg pcReg (
        .clk    (clk),
        .rst    (rst),
        .load   (pcLoad),
        .jump   (cr[JUMP_BIT]),
        .target (ir[PC_W-1:0]),
        .pc     (pc)
    );

    assign bus.pc_o     = pc;
    assign bus.ir_o     = ir;
    assign bus.cr_o     = cr;
    assign bus.ret_cnt  = retCnt;
    assign bus.step_ack = stepAck;
    assign bus.phase_o  = state;
    assign bus.halted   = (state == HALT);
    assign bus.addr_en  = (state == DECODE) && !cr[HALT_BIT];
    assign bus.ram_we   = (state == EXEC) && cr[WE_BIT];
    assign bus.acc_en   = (state == WRITE) && !cr[WE_BIT];

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: random ROM contents, an
// instruction-level reference model and directed run/step/jump/halt scenarios.
module tb_instr_sequencer;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    instr_sequencer_if bus ();

    instr_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0] progRom [16];
    logic [9:0] ctrlRom [16];

    assign bus.instr_i = progRom[bus.pc_o];
    assign bus.ctrl_i  = ctrlRom[bus.instr_i[3:0]];

    int checks = 0;
    int errors = 0;
    int mPc    = 0;
    int mRet   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic run, input logic step);
        bus.run_i    = run;
        bus.step_req = step;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ROM fill: halt is never set; jumps only when allowJump.
    task automatic fillRom(input bit allowJump);
        for (int i = 0; i < 16; i++) begin
            progRom[i] = 8'($urandom);
            ctrlRom[i] = 10'($urandom) & (allowJump ? 10'h3FE : 10'h3FA);
        end
    endtask

    task automatic checkAfter(input int expPhase, input int expAck);
        checkOutput("after.phase", bus.phase_o, expPhase);
        checkOutput("after.ack", bus.step_ack, expAck);
        checkOutput("after.pc", bus.pc_o, mPc);
        checkOutput("after.ret", bus.ret_cnt, mRet);
    endtask

    // Walks one instruction from FETCH through WRITE (or into HALT).
    // hook 1: drop run in DECODE, raise step in EXEC; hook 2: raise run in EXEC.
    task automatic checkInstruction(input int hook);
        logic [7:0] instr;
        logic [9:0] ctrl;
        instr = progRom[mPc];
        ctrl  = ctrlRom[instr[3:0]];
        checkOutput("fetch.phase", bus.phase_o, 1);
        checkOutput("fetch.pc", bus.pc_o, mPc);
        checkOutput("fetch.enables", {bus.addr_en, bus.ram_we, bus.acc_en}, 0);
        tick();
        checkOutput("decode.phase", bus.phase_o, 2);
        checkOutput("decode.ir", bus.ir_o, instr);
        checkOutput("decode.cr", bus.cr_o, ctrl);
        if (hook == 1) bus.run_i = 1'b0;
        if (ctrl[0]) begin
            checkOutput("decode.haltEnables", {bus.addr_en, bus.ram_we, bus.acc_en}, 0);
            tick();
            checkOutput("halt.phase", bus.phase_o, 5);
            checkOutput("halt.halted", bus.halted, 1);
            checkOutput("halt.pc", bus.pc_o, mPc);
            checkOutput("halt.enables", {bus.addr_en, bus.ram_we, bus.acc_en}, 0);
        end else begin
            checkOutput("decode.enables", {bus.addr_en, bus.ram_we, bus.acc_en}, 3'b100);
            tick();
            checkOutput("exec.phase", bus.phase_o, 3);
            checkOutput("exec.enables", {bus.addr_en, bus.ram_we, bus.acc_en},
                        {1'b0, ctrl[1], 1'b0});
            checkOutput("exec.ack", bus.step_ack, 0);
            if (hook == 1) bus.step_req = 1'b1;
            if (hook == 2) bus.run_i = 1'b1;
            tick();
            checkOutput("write.phase", bus.phase_o, 4);
            checkOutput("write.enables", {bus.addr_en, bus.ram_we, bus.acc_en},
                        {2'b00, !ctrl[1]});
            checkOutput("write.pc", bus.pc_o, mPc);
            checkOutput("write.ret", bus.ret_cnt, mRet);
            mPc  = ctrl[2] ? int'(instr[3:0]) : (mPc + 1) % 16;
            mRet = (mRet + 1) % 256;
        end
    endtask

    task automatic resetDut();
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0);
        tick();
        tick();
        checkOutput("reset.phase", bus.phase_o, 0);
        checkOutput("reset.pc", bus.pc_o, 0);
        checkOutput("reset.ret", bus.ret_cnt, 0);
        checkOutput("reset.flags", {bus.halted, bus.step_ack, bus.addr_en, bus.ram_we, bus.acc_en}, 0);
        rst  = 1'b0;
        mPc  = 0;
        mRet = 0;
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0);
        fillRom(1'b0);
        ctrlRom[progRom[0][3:0]][1] = 1'b1;
        resetDut();

        // Free run through all 16 addresses with no jumps.
        applyStimulus(1'b1, 1'b0);
        tick();
        for (int i = 0; i < 16; i++) begin
            checkInstruction(0);
            tick();
            checkAfter(1, 0);
        end
        checkOutput("run.wrapPc", bus.pc_o, 0);
        checkOutput("run.ret16", bus.ret_cnt, 16);

        // Reset in the middle of a store's EXEC cycle.
        tick();
        tick();
        checkOutput("rstMid.ramWe", bus.ram_we, 1);
        rst = 1'b1;
        tick();
        checkOutput("rstMid.phase", bus.phase_o, 0);
        checkOutput("rstMid.pc", bus.pc_o, 0);
        checkOutput("rstMid.ramWe0", bus.ram_we, 0);
        checkOutput("rstMid.ret", bus.ret_cnt, 0);
        checkOutput("rstMid.halted", bus.halted, 0);
        resetDut();

        // Jump at pc 3 to operand A, then a random program with jumps.
        fillRom(1'b0);
        for (int i = 0; i < 3; i++) progRom[i][3:0] = 4'(i);
        progRom[3] = {4'($urandom), 4'hA};
        ctrlRom[10] = (ctrlRom[10] | 10'h004) & 10'h3FD;
        applyStimulus(1'b1, 1'b0);
        tick();
        for (int i = 0; i < 4; i++) begin
            checkInstruction(0);
            tick();
            checkAfter(1, 0);
        end
        checkOutput("jump.pc", bus.pc_o, 10);
        fillRom(1'b1);
        for (int i = 0; i < 24; i++) begin
            checkInstruction(0);
            tick();
            checkAfter(1, 0);
        end
        applyStimulus(1'b0, 1'b0);
        checkInstruction(0);
        tick();
        checkAfter(0, 0);

        // Single step with step_req held high.
        resetDut();
        fillRom(1'b0);
        applyStimulus(1'b0, 1'b1);
        tick();
        checkInstruction(0);
        tick();
        checkAfter(0, 1);
        checkOutput("step.pc", bus.pc_o, 1);
        for (int i = 0; i < 15; i++) begin
            tick();
            checkAfter(0, 0);
        end
        applyStimulus(1'b0, 1'b0);
        tick();
        checkAfter(0, 0);
        applyStimulus(1'b0, 1'b1);
        tick();
        checkInstruction(2);
        tick();
        checkAfter(0, 1);
        tick();
        checkAfter(1, 0);
        applyStimulus(1'b1, 1'b0);
        checkInstruction(1);
        tick();
        checkAfter(0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkAfter(0, 0);
        end

        // Store followed by halt; HALT ignores run and step until reset.
        resetDut();
        fillRom(1'b0);
        ctrlRom[5] = 10'h002;
        ctrlRom[6] = 10'h001;
        progRom[0] = {4'($urandom), 4'h5};
        progRom[1] = {4'($urandom), 4'h6};
        applyStimulus(1'b1, 1'b0);
        tick();
        checkInstruction(0);
        tick();
        checkAfter(1, 0);
        checkInstruction(0);
        checkOutput("halt.pcHeld", bus.pc_o, 1);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'($urandom), 1'($urandom));
            tick();
            checkOutput("halt.stay", bus.phase_o, 5);
            checkOutput("halt.flag", bus.halted, 1);
            checkOutput("halt.pcStay", bus.pc_o, 1);
            checkOutput("halt.quiet", {bus.addr_en, bus.ram_we, bus.acc_en, bus.step_ack}, 0);
        end
        resetDut();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
